// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller FSM state encoding (2 bits)
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fs_cell.sv
// 1-bit full subtractor cell, purely combinational.
//   x  : minuend bit
//   y  : subtrahend bit
//   c  : borrow in
//   d  : difference bit, x - y - c
//   bo : borrow out
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ c;
    assign bo = (~x & y) | (~(x ^ y) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller. A single fs_cell is stepped
// LSB-first over WIDTH cycles; the running borrow lives in a flop.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (accept only in IDLE)
//   a, b, bin            : minuend, subtrahend, borrow-in (captured at accept)
//   out_valid / out_ready: result handshake (valid only in DONE)
//   diff, bout           : (a - b - bin) mod 2^WIDTH, borrow-out
//   busy                 : high while the serial sweep is running
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_a_q, sr_a_d;
    logic [WIDTH-1:0] sr_b_q, sr_b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    logic cell_d, cell_bo;

    fs_cell u_cell (
        .x  (sr_a_q[0]),
        .y  (sr_b_q[0]),
        .c  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_a_q  <= '0;
            sr_b_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_a_q  <= sr_a_d;
            sr_b_q  <= sr_b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_a_d  = sr_a_q;
        sr_b_d  = sr_b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                // in_ready is high whenever we are here, so in_valid alone is an accept.
                if (in_valid) begin
                    sr_a_d  = a;
                    sr_b_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB; after WIDTH steps bit 0 lands at diff[0].
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                sr_a_d = sr_a_q >> 1;
                sr_b_d = sr_b_q >> 1;
                brw_d  = cell_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule
